branch_sequencer: RTL and testbench
===================================

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 The block SHALL have these ports, one per line:
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE and begin fetching.
- opcode  in  4  opcode field of the loaded instruction register.
- cond  in  4  condition field of a branch instruction.
- cc  in  1  selected condition bit returned by status selection for cond_sel.
- mem_ready  in  1  memory completes the current access this cycle.
- cond_sel  out  4  condition select to status selection.
- flag_ld  out  1  load enable for the V/C/Z/S flag flops.
- ir_ld, pc_inc, pc_ld  out  1 each  instruction register load, PC increment, PC load (branch target).
- alu_en, mem_rd, mem_wr, reg_wr  out  1 each  datapath strobes.
- branch_taken, illegal  out  1 each  one-cycle status pulses.
- busy, halted, fault  out  1 each  status levels.
- state  out  3  current state encoding.
- retired  out  16  retired-instruction count.

Function
REQ-002 State encoding SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, BRANCH=6, HALT=7.
REQ-003 The opcode map SHALL be 0000 NOP, 0001 ALU, 0010 LOAD, 0011 STORE, 0100 BR, 1111 HALT; all other opcodes are illegal.
REQ-004 IDLE: start=1 SHALL go to FETCH; otherwise stay in IDLE.
REQ-005 FETCH: mem_rd=1; while mem_ready=0, stay in FETCH; in the cycle mem_ready=1, assert ir_ld=1 and pc_inc=1 and go to DECODE.
REQ-006 DECODE transitions SHALL be:
- NOP -> FETCH.
- ALU, LOAD, STORE -> EXEC.
- BR -> BRANCH.
- HALT -> HALT.
- Illegal -> FETCH with illegal=1 for that cycle.
REQ-007 EXEC: alu_en=1; ALU SHALL assert flag_ld=1 and go to WB; LOAD and STORE SHALL go to MEM with no flag_ld.
REQ-008 MEM: LOAD asserts mem_rd, STORE asserts mem_wr, held until mem_ready=1; then LOAD -> WB and STORE -> FETCH.
REQ-009 WB: reg_wr=1 for one cycle, then FETCH.
REQ-010 BRANCH timing:
- cond_sel SHALL equal cond.
- If cc=1: pc_ld=1 and branch_taken=1 in the same cycle.
- Next state is FETCH regardless of cc.
- cc SHALL be sampled combinationally in BRANCH; flags loaded by a preceding ALU EXEC are visible here.
REQ-011 cond_sel SHALL be 0000 in every state other than BRANCH.
REQ-012 Memory wait timer:
- A 4-bit counter clears on entry to FETCH or MEM.
- It increments each cycle mem_ready=0 in those states.
- When it reaches 15 with mem_ready still 0, the next state SHALL be HALT, fault is set, and no strobe is issued on that edge.
REQ-013 mem_ready=1 on the same cycle the counter reaches 15 SHALL complete the access normally, with no fault.
REQ-014 HALT: halted=1 and all strobes are 0; the block stays in HALT until reset, and start is ignored.
REQ-015 busy SHALL be 1 in every state except IDLE and HALT.
REQ-016 retired SHALL increment by 1 on each transition into FETCH from DECODE (NOP or illegal), WB, MEM (STORE) or BRANCH, and SHALL wrap from 0xFFFF to 0x0000.
REQ-017 All strobes SHALL be decoded combinationally from state, opcode and mem_ready; state, the counters and fault SHALL be registered.

Reset
REQ-018 Asserting reset_n=0 SHALL immediately force state=IDLE, both counters and fault to 0, all strobes 0, and cond_sel=0000, including mid-access.
REQ-019 After reset_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-020 Bench scenarios:
- ALU: reset, start, mem_ready=1 each cycle, opcode=0001 -> state sequence 1,2,3,5,1; flag_ld high in EXEC only; retired=1.
- Branch taken: opcode=0100, cond=0100, cc=1 -> cond_sel=0100, pc_ld=1 and branch_taken=1 in BRANCH; back to FETCH.
- Branch not taken: same as above with cc=0 -> pc_ld=0, branch_taken=0; retired still increments.
- LOAD with wait states: mem_ready held low 3 cycles in MEM -> mem_rd held 4 cycles, then WB with reg_wr=1.
- Timeout and reset: mem_ready held 0 in FETCH -> HALT after 16 cycles with fault=1 and halted=1; reset_n=0 -> IDLE, fault=0.
- Illegal opcode and wrap: opcode=1010 -> illegal one-cycle pulse, then FETCH; preload retired=0xFFFF and retire one -> retired=0x0000.

Source files
------------

// File: rtl/branch_sequencer_if.sv
// Signal bundle between the branch sequencer and its surrounding datapath.
// The slave side is the sequencer; the master side drives the instruction fields and memory handshake.
interface branch_sequencer_if;
    logic        start;
    logic [3:0]  opcode;
    logic [3:0]  cond;
    logic        cc;
    logic        mem_ready;
    logic [3:0]  cond_sel;
    logic        flag_ld;
    logic        ir_ld;
    logic        pc_inc;
    logic        pc_ld;
    logic        alu_en;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        branch_taken;
    logic        illegal;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [2:0]  state;
    logic [15:0] retired;

    modport slave (
        input  start, opcode, cond, cc, mem_ready,
        output cond_sel, flag_ld, ir_ld, pc_inc, pc_ld, alu_en, mem_rd, mem_wr,
               reg_wr, branch_taken, illegal, busy, halted, fault, state, retired
    );

    modport master (
        output start, opcode, cond, cc, mem_ready,
        input  cond_sel, flag_ld, ir_ld, pc_inc, pc_ld, alu_en, mem_rd, mem_wr,
               reg_wr, branch_taken, illegal, busy, halted, fault, state, retired
    );
endinterface

// File: rtl/branch_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback/branch control
// with a memory wait watchdog that parks the block in HALT on a stuck access.
module branch_sequencer (
    input  logic              clk,
    input  logic              reset_n,
    branch_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_BRANCH = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_ALU   = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b0011;
    localparam logic [3:0] OP_BR    = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_wait;
    logic [15:0] r_retired;
    logic        r_fault;

    logic [3:0]  w_cond_sel;
    logic        w_flag_ld, w_ir_ld, w_pc_inc, w_pc_ld, w_alu_en;
    logic        w_mem_rd, w_mem_wr, w_reg_wr, w_branch_taken, w_illegal;
    logic        w_timeout;
    logic        w_retire;
    logic        w_wait_clr;
    logic        w_wait_inc;

    always_comb begin
        w_next         = r_state;
        w_cond_sel     = 4'b0000;
        w_flag_ld      = 1'b0;
        w_ir_ld        = 1'b0;
        w_pc_inc       = 1'b0;
        w_pc_ld        = 1'b0;
        w_alu_en       = 1'b0;
        w_mem_rd       = 1'b0;
        w_mem_wr       = 1'b0;
        w_reg_wr       = 1'b0;
        w_branch_taken = 1'b0;
        w_illegal      = 1'b0;
        w_timeout      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_ld  = 1'b1;
                    w_pc_inc = 1'b1;
                    w_next   = S_DECODE;
                end else if (r_wait == 4'hF) begin
                    w_timeout = 1'b1;
                    w_next    = S_HALT;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_NOP:                   w_next = S_FETCH;
                    OP_ALU, OP_LOAD, OP_STORE: w_next = S_EXEC;
                    OP_BR:                    w_next = S_BRANCH;
                    OP_HALT:                  w_next = S_HALT;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                w_alu_en = 1'b1;
                if (bus.opcode == OP_ALU) begin
                    w_flag_ld = 1'b1;
                    w_next    = S_WB;
                end else if (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEM: begin
                w_mem_rd = (bus.opcode == OP_LOAD);
                w_mem_wr = (bus.opcode == OP_STORE);
                if (bus.mem_ready) begin
                    w_next = (bus.opcode == OP_LOAD) ? S_WB : S_FETCH;
                end else if (r_wait == 4'hF) begin
                    w_timeout = 1'b1;
                    w_next    = S_HALT;
                end
            end
            S_WB: begin
                w_reg_wr = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                // cc comes back combinationally from status selection driven by cond_sel
                w_cond_sel = bus.cond;
                if (bus.cc) begin
                    w_pc_ld        = 1'b1;
                    w_branch_taken = 1'b1;
                end
                w_next = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_retire   = (w_next == S_FETCH) &&
                        (r_state == S_DECODE || r_state == S_WB ||
                         r_state == S_MEM    || r_state == S_BRANCH);
    assign w_wait_clr = (w_next == S_FETCH || w_next == S_MEM) && (w_next != r_state);
    assign w_wait_inc = (r_state == S_FETCH || r_state == S_MEM) && !bus.mem_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_wait    <= 4'd0;
            r_retired <= 16'd0;
            r_fault   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_wait_clr) begin
                r_wait <= 4'd0;
            end else if (w_wait_inc) begin
                r_wait <= r_wait + 4'd1;
            end
            if (w_retire) r_retired <= r_retired + 16'd1;
            if (w_timeout) r_fault <= 1'b1;
        end
    end

    assign bus.cond_sel     = w_cond_sel;
    assign bus.flag_ld      = w_flag_ld;
    assign bus.ir_ld        = w_ir_ld;
    assign bus.pc_inc       = w_pc_inc;
    assign bus.pc_ld        = w_pc_ld;
    assign bus.alu_en       = w_alu_en;
    assign bus.mem_rd       = w_mem_rd;
    assign bus.mem_wr       = w_mem_wr;
    assign bus.reg_wr       = w_reg_wr;
    assign bus.branch_taken = w_branch_taken;
    assign bus.illegal      = w_illegal;
    assign bus.busy         = (r_state != S_IDLE) && (r_state != S_HALT);
    assign bus.halted       = (r_state == S_HALT);
    assign bus.fault        = r_fault;
    assign bus.state        = r_state;
    assign bus.retired      = r_retired;
endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: instruction flows, branch outcomes, memory waits,
// watchdog timeout, asynchronous reset and retired-count wrap.
module tb_branch_sequencer;
    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;
    int   cnt;

    branch_sequencer_if bus ();

    branch_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.opcode    = 4'b0001;
        bus.cond      = 4'b0000;
        bus.cc        = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        check("rst_state",   32'(bus.state), 32'd0);
        check("rst_busy",    32'(bus.busy), 32'd0);
        check("rst_retired", 32'(bus.retired), 32'd0);
        check("rst_fault",   32'(bus.fault), 32'd0);
        check("rst_condsel", 32'(bus.cond_sel), 32'd0);
        reset_n = 1'b1;

        // ALU instruction: 1,2,3,5,1
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        check("alu_fetch",     32'(bus.state), 32'd1);
        check("alu_fetch_str", 32'({bus.mem_rd, bus.ir_ld, bus.pc_inc, bus.flag_ld}), 32'b1110);
        check("alu_busy",      32'(bus.busy), 32'd1);
        tick();
        check("alu_decode",    32'(bus.state), 32'd2);
        check("alu_dec_flag",  32'(bus.flag_ld), 32'd0);
        tick();
        check("alu_exec",      32'(bus.state), 32'd3);
        check("alu_exec_str",  32'({bus.alu_en, bus.flag_ld}), 32'b11);
        tick();
        check("alu_wb",        32'(bus.state), 32'd5);
        check("alu_wb_str",    32'({bus.reg_wr, bus.flag_ld}), 32'b10);
        tick();
        check("alu_back",      32'(bus.state), 32'd1);
        check("alu_retired",   32'(bus.retired), 32'd1);

        // Branch taken
        bus.opcode = 4'b0100;
        bus.cond   = 4'b0100;
        bus.cc     = 1'b1;
        tick();
        check("brt_decode", 32'(bus.state), 32'd2);
        tick();
        check("brt_state",   32'(bus.state), 32'd6);
        check("brt_condsel", 32'(bus.cond_sel), 32'h4);
        check("brt_strobes", 32'({bus.pc_ld, bus.branch_taken}), 32'b11);
        tick();
        check("brt_back",    32'(bus.state), 32'd1);
        check("brt_condsel0", 32'(bus.cond_sel), 32'h0);
        check("brt_retired", 32'(bus.retired), 32'd2);

        // Branch not taken
        bus.cc = 1'b0;
        tick();
        tick();
        check("brn_state",   32'(bus.state), 32'd6);
        check("brn_condsel", 32'(bus.cond_sel), 32'h4);
        check("brn_strobes", 32'({bus.pc_ld, bus.branch_taken}), 32'b00);
        tick();
        check("brn_back",    32'(bus.state), 32'd1);
        check("brn_retired", 32'(bus.retired), 32'd3);

        // LOAD with three wait states in MEM
        bus.opcode = 4'b0010;
        tick();
        tick();
        check("ld_exec", 32'({bus.state, bus.alu_en, bus.flag_ld}), 32'({3'd3, 1'b1, 1'b0}));
        tick();
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = (i == 3);
            #1;
            check("ld_mem_state", 32'(bus.state), 32'd4);
            if (bus.mem_rd) cnt++;
            tick();
        end
        check("ld_memrd_cycles", 32'(cnt), 32'd4);
        check("ld_wb", 32'({bus.state, bus.reg_wr}), 32'({3'd5, 1'b1}));
        tick();
        check("ld_retired", 32'(bus.retired), 32'd4);

        // STORE, no wait
        bus.opcode = 4'b0011;
        tick();
        tick();
        tick();
        check("st_mem", 32'({bus.state, bus.mem_wr, bus.mem_rd}), 32'({3'd4, 1'b1, 1'b0}));
        tick();
        check("st_back",    32'(bus.state), 32'd1);
        check("st_retired", 32'(bus.retired), 32'd5);

        // Illegal opcode
        bus.opcode = 4'b1010;
        tick();
        check("ill_pulse", 32'({bus.state, bus.illegal}), 32'({3'd2, 1'b1}));
        tick();
        check("ill_back",    32'({bus.state, bus.illegal}), 32'({3'd1, 1'b0}));
        check("ill_retired", 32'(bus.retired), 32'd6);

        // Ready arriving on the last allowed wait cycle completes normally
        bus.opcode    = 4'b0000;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("edge_still_fetch", 32'(bus.state), 32'd1);
        bus.mem_ready = 1'b1;
        #1;
        check("edge_irld", 32'(bus.ir_ld), 32'd1);
        tick();
        check("edge_decode", 32'(bus.state), 32'd2);
        check("edge_nofault", 32'(bus.fault), 32'd0);
        tick();
        check("nop_retired", 32'(bus.retired), 32'd7);

        // Retired-count wrap from 0xFFFF
        dut.r_retired = 16'hFFFF;
        #1;
        tick();
        tick();
        check("wrap_state",   32'(bus.state), 32'd1);
        check("wrap_retired", 32'(bus.retired), 32'd0);

        // Memory timeout in FETCH
        bus.mem_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40 && bus.state != 3'd7; i++) begin
            tick();
            cnt++;
        end
        check("to_cycles", 32'(cnt), 32'd16);
        check("to_state",  32'(bus.state), 32'd7);
        check("to_flags",  32'({bus.fault, bus.halted, bus.busy}), 32'b110);
        check("to_strobes", 32'({bus.mem_rd, bus.mem_wr, bus.ir_ld, bus.pc_inc, bus.reg_wr,
                                 bus.alu_en, bus.flag_ld, bus.pc_ld}), 32'd0);
        bus.start     = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        check("halt_sticky", 32'(bus.state), 32'd7);

        // Asynchronous reset between clock edges
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_state", 32'(bus.state), 32'd0);
        check("arst_fault", 32'({bus.fault, bus.halted}), 32'b00);
        check("arst_retired", 32'(bus.retired), 32'd0);
        bus.start = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(bus.state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
